mux0_uart: RTL and testbench
============================

# mux0_uart

Memory-mapped transmit controller for MUX port 0, the console channel the CPU6 firmware polls at F200/F201. It decodes the CPU bus, buffers bytes in a small FIFO, and serializes them 8N1 on `txd` with a programmable bit period. It replaces the bench-side "pretend UART" decode and the constant status read, with real busy/ready sequencing.

## Interface
- `BASE_ADDR`, 16'hF200: status register address; data register at `BASE_ADDR+1`.
- `CLKS_PER_BIT`, 16: clocks per serial bit, ≥2.
- `FIFO_DEPTH`, 4: TX FIFO entries, power of two, ≥2.

- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `address`  in  16  CPU bus address.
- `write_en`  in  1  CPU bus write strobe, sampled on rising edge.
- `data_in`  in  8  CPU write data.
- `sel`  out  1  combinational: `address` is `BASE_ADDR` or `BASE_ADDR+1`.
- `data_out`  out  8  combinational read data, 0 when `sel`=0.
- `txd`  out  1  serial output, idle high.
- `tx_busy`  out  1  high while FIFO non-empty or a frame is in progress.

## Operation
- Status (`BASE_ADDR`) read: bit1 = TX ready (FIFO not full), bit3 = TX idle (FSM IDLE and FIFO empty), bit7 = overrun (sticky), others 0. Reset read value 8'h0A.
- Status write (any data): clears overrun. No other effect.
- Data (`BASE_ADDR+1`) write: pushes `data_in` into FIFO. If FIFO full (count before any same-cycle pop), byte dropped, overrun set.
- Data read: returns 8'h00, no side effects. Reads never have side effects.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1; if FIFO non-empty, pop head into shift register, go START.
  - START: `txd`=0 for `CLKS_PER_BIT` clocks, go DATA.
  - DATA: bits LSB first, each `CLKS_PER_BIT` clocks; after bit 7, go STOP.
  - STOP: `txd`=1 for `CLKS_PER_BIT` clocks; at end, if FIFO non-empty pop and go START directly (back-to-back), else IDLE.
- Bit counter 3 bits; baud counter width clog2(`CLKS_PER_BIT`), reloads to 0 at each bit boundary.
- FIFO count width clog2(`FIFO_DEPTH`)+1; pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset values: `txd`=1, `tx_busy`=0, FSM IDLE, FIFO empty, overrun 0, counters 0.
- Write at edge N into empty FIFO while IDLE: `tx_busy`=1 after N; pop at edge N+1, `txd`=0 after N+1.
- Frame length exactly 10×`CLKS_PER_BIT` clocks; consecutive queued bytes have no gap.
- Status bits reflect registered state after the edge; a write at edge N is visible in status reads after N.
- Simultaneous push and pop when not full: both occur, count unchanged.
- Simultaneous push and pop when full: push dropped, overrun set, pop proceeds.
- Reset asserted mid-frame: on that edge `txd`=1, FIFO flushed, overrun cleared, FSM IDLE; the partial frame is abandoned.
- `tx_busy` falls on the edge where STOP ends with the FIFO empty.

## Structure
- Shared package `mux_pkg`: register offsets (STATUS=0, DATA=1), status bit positions (TX_READY=1, TX_IDLE=3, OVERRUN=7), FSM state enum.
- Sub-module `byte_fifo` (parameterized depth, push/pop/full/empty/count); the FSM, decode and shifter stay in `mux0_uart`.

## Test plan
- Reset, read F200 -> 8'h0A; `txd`=1, `tx_busy`=0.
- Write 8'h48 to F201, `CLKS_PER_BIT`=4 -> `txd` low 2 edges later, bits 0,0,0,1,0,0,1,0 then stop 1; 40 clocks per frame; status returns 8'h0A after.
- Write "HI\r\n" back-to-back -> four contiguous frames, 160 clocks, no idle between; `tx_busy` high throughout.
- Write 6 bytes with `FIFO_DEPTH`=4 in consecutive cycles -> first byte popped, next 4 queued, 6th dropped; status bit7=1, bit1=0; write F200 -> bit7 clears.
- Assert reset during DATA bit 3 of 8'h55 -> `txd`=1 next edge, status 8'h0A, no further edges on `txd`.
- Drive `address`=F202 and F1FF with `write_en`=1 -> `sel`=0, `data_out`=0, FIFO unchanged.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the MUX console port: register offsets, status bit
// positions and transmitter FSM states.
package mux_pkg;

    localparam logic [15:0] REG_STATUS = 16'd0;
    localparam logic [15:0] REG_DATA   = 16'd1;

    localparam int TX_READY_BIT = 1;
    localparam int TX_IDLE_BIT  = 3;
    localparam int OVERRUN_BIT  = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    function automatic logic [7:0] status_byte(input logic ready, input logic idle,
                                               input logic overrun);
        logic [7:0] s;
        s = 8'h00;
        s[TX_READY_BIT] = ready;
        s[TX_IDLE_BIT]  = idle;
        s[OVERRUN_BIT]  = overrun;
        return s;
    endfunction

endpackage

// File: rtl/mux0_uart_byte_fifo.sv
// Byte-wide FIFO with power-of-two depth; head is presented combinationally
// on dout so a pop and the load of the consumer happen on the same edge.
module byte_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Fullness is judged on the count before any same-cycle pop.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mux0_uart.sv
// Console transmit channel for MUX port 0: bus decode of status/data
// registers, TX FIFO and an 8N1 serializer with a programmable bit period.
module mux0_uart
    import mux_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'hF200,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic        sel,
    output logic [7:0]  data_out,
    output logic        txd,
    output logic        tx_busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] LAST_CLK = BW'(CLKS_PER_BIT - 1);

    tx_state_t     state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shreg, shreg_n;
    logic          overrun;
    logic          bit_end;

    logic          hit_status, hit_data;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          tx_idle, tx_ready;

    assign hit_status = (address == BASE_ADDR + REG_STATUS);
    assign hit_data   = (address == BASE_ADDR + REG_DATA);
    assign sel        = hit_status || hit_data;
    assign fifo_push  = write_en && hit_data;

    assign tx_idle  = (state == ST_IDLE) && fifo_empty;
    assign tx_ready = (fifo_count < CW'(FIFO_DEPTH));
    assign tx_busy  = !fifo_empty || (state != ST_IDLE);
    assign data_out = hit_status ? status_byte(tx_ready, tx_idle, overrun) : 8'h00;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .din   (data_in),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Status write clears overrun; a data write into a full FIFO sets it.
    always_ff @(posedge clock) begin
        if (reset)                          overrun <= 1'b0;
        else if (write_en && hit_status)    overrun <= 1'b0;
        else if (fifo_push && fifo_full)    overrun <= 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
        end
    end

    assign bit_end = (baud_cnt == LAST_CLK);

    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_cnt;
        shreg_n  = shreg;
        fifo_pop = 1'b0;
        txd      = 1'b1;
        if (state != ST_IDLE) baud_n = bit_end ? '0 : baud_cnt + BW'(1);
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_n  = fifo_dout;
                    baud_n   = '0;
                    state_n  = ST_START;
                end
            end
            ST_START: begin
                txd = 1'b0;
                if (bit_end) begin
                    bit_n   = '0;
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                txd = shreg[0];
                if (bit_end) begin
                    shreg_n = {1'b0, shreg[7:1]};
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                // Chain straight into the next start bit when more data waits.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_n  = fifo_dout;
                        state_n  = ST_START;
                    end else begin
                        state_n  = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux0_uart.sv
// Directed bench for mux0_uart with a 4-clock bit period and a 4-entry FIFO.
module tb_mux0_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic        write_en;
    logic [7:0]  data_in;
    logic        sel;
    logic [7:0]  data_out;
    logic        txd;
    logic        tx_busy;

    int vectors    = 0;
    int miscompares = 0;

    mux0_uart #(.BASE_ADDR(16'hF200), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .write_en (write_en),
        .data_in  (data_in),
        .sel      (sel),
        .data_out (data_out),
        .txd      (txd),
        .tx_busy  (tx_busy)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; write_en = 1'b0; address = 16'h0000; data_in = 8'h00;
        step; step;
        vectors++;
        if (txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd got %b want 1", txd); end
        vectors++;
        if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", tx_busy); end
        reset = 1'b0;
        step;
        address = 16'hF200; #1;
        vectors++;
        if (sel !== 1'b1) begin miscompares++; $display("FAIL reset_sel got %b want 1", sel); end
        vectors++;
        if (data_out !== 8'h0A) begin miscompares++; $display("FAIL reset_status got %h want 0a", data_out); end
    endtask

    // Writes n bytes on consecutive edges and checks every serial sample.
    task automatic test_frames(input logic [7:0] b [4], input int n, input string name);
        int k;
        int pos;
        logic [7:0] cur;
        logic exp;
        address = 16'hF201;
        for (int c = 0; c <= n * 40 + 1; c++) begin
            if (c < n) begin write_en = 1'b1; data_in = b[c]; end
            else write_en = 1'b0;
            step;
            k = c - 1;
            if (k < 0) begin
                vectors++;
                if (tx_busy !== 1'b1 || txd !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s first_edge busy/txd got %b%b want 11", name, tx_busy, txd);
                end
            end else if (k < n * 40) begin
                cur = b[k / 40];
                pos = (k % 40) / CPB;
                exp = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : cur[pos - 1];
                vectors++;
                if (txd !== exp) begin
                    miscompares++;
                    $display("FAIL %s txd k=%0d got %b want %b", name, k, txd, exp);
                end
                vectors++;
                if (tx_busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s busy k=%0d got %b want 1", name, k, tx_busy);
                end
            end else begin
                vectors++;
                if (tx_busy !== 1'b0 || txd !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s end busy/txd got %b%b want 01", name, tx_busy, txd);
                end
            end
        end
        write_en = 1'b0;
        address = 16'hF200; #1;
        vectors++;
        if (data_out !== 8'h0A) begin
            miscompares++;
            $display("FAIL %s status_after got %h want 0a", name, data_out);
        end
    endtask

    task automatic test_overrun;
        int e;
        address = 16'hF201;
        for (int c = 0; c < 6; c++) begin
            write_en = 1'b1; data_in = 8'hA0 + 8'(c);
            step;
        end
        write_en = 1'b0;
        address = 16'hF200; #1;
        vectors++;
        if (data_out !== 8'h80) begin miscompares++; $display("FAIL overrun_status got %h want 80", data_out); end
        write_en = 1'b1; data_in = 8'hFF;
        step;
        write_en = 1'b0; #1;
        vectors++;
        if (data_out !== 8'h00) begin miscompares++; $display("FAIL overrun_clear got %h want 00", data_out); end
        // Five frames starting at write-edge +1 means busy drops at edge +201.
        e = 6;
        while (tx_busy && e < 400) begin step; e++; end
        vectors++;
        if (e != 201) begin miscompares++; $display("FAIL overrun_drain_edge got %0d want 201", e); end
        vectors++;
        if (data_out !== 8'h0A) begin miscompares++; $display("FAIL overrun_final_status got %h want 0a", data_out); end
    endtask

    task automatic test_decode;
        logic [15:0] addrs [2];
        addrs[0] = 16'hF202;
        addrs[1] = 16'hF1FF;
        for (int i = 0; i < 2; i++) begin
            address = addrs[i]; write_en = 1'b1; data_in = 8'h5A; #1;
            vectors++;
            if (sel !== 1'b0 || data_out !== 8'h00) begin
                miscompares++;
                $display("FAIL decode_%h sel/data got %b/%h want 0/00", addrs[i], sel, data_out);
            end
            step;
            write_en = 1'b0;
        end
        step;
        vectors++;
        if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL decode_busy got %b want 0", tx_busy); end
        address = 16'hF201; #1;
        vectors++;
        if (sel !== 1'b1 || data_out !== 8'h00) begin
            miscompares++;
            $display("FAIL decode_data_read sel/data got %b/%h want 1/00", sel, data_out);
        end
        address = 16'hF200; #1;
        vectors++;
        if (data_out !== 8'h0A) begin miscompares++; $display("FAIL decode_status got %h want 0a", data_out); end
    endtask

    task automatic test_reset_midframe;
        address = 16'hF201; write_en = 1'b1; data_in = 8'h55;
        step;
        write_en = 1'b0;
        for (int k = 0; k <= 16; k++) step;
        vectors++;
        if (txd !== 1'b0) begin miscompares++; $display("FAIL midframe_bit3 got %b want 0", txd); end
        reset = 1'b1;
        step;
        reset = 1'b0;
        vectors++;
        if (txd !== 1'b1 || tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_reset txd/busy got %b%b want 10", txd, tx_busy);
        end
        address = 16'hF200; #1;
        vectors++;
        if (data_out !== 8'h0A) begin miscompares++; $display("FAIL midframe_status got %h want 0a", data_out); end
        for (int k = 0; k < 60; k++) begin
            step;
            vectors++;
            if (txd !== 1'b1 || tx_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL midframe_quiet k=%0d txd/busy got %b%b want 10", k, txd, tx_busy);
            end
        end
    endtask

    initial begin
        logic [7:0] msg [4];
        test_reset;
        msg = '{8'h48, 8'h00, 8'h00, 8'h00};
        test_frames(msg, 1, "single_48");
        msg = '{8'h48, 8'h49, 8'h0D, 8'h0A};
        test_frames(msg, 4, "hi_crlf");
        test_overrun;
        test_decode;
        test_reset_midframe;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
